// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: walks an active-low column drive, debounces one key
// press/release on the synchronized rows, and reports a hex code with a strobe.
module hex_keypad_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);
  localparam int CMAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        r_state, w_state_nx;
  logic [3:0]    r_row_m, r_row_s;
  logic [1:0]    r_col, w_col_nx;
  logic [1:0]    r_row, w_row_nx;
  logic [CW-1:0] r_dwell, w_dwell_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [3:0]    r_key, w_key_nx;
  logic          r_valid, w_valid_nx;
  logic          r_held, w_held_nx;
  logic          w_row_low;
  logic [CW-1:0] w_cnt_inc;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: return 4'h1;  4'b00_01: return 4'h2;
      4'b00_10: return 4'h3;  4'b00_11: return 4'hA;
      4'b01_00: return 4'h4;  4'b01_01: return 4'h5;
      4'b01_10: return 4'h6;  4'b01_11: return 4'hB;
      4'b10_00: return 4'h7;  4'b10_01: return 4'h8;
      4'b10_10: return 4'h9;  4'b10_11: return 4'hC;
      4'b11_00: return 4'hE;  4'b11_01: return 4'h0;
      4'b11_10: return 4'hF;  default:  return 4'hD;
    endcase
  endfunction

  assign w_row_low = ~r_row_s[r_row];
  assign w_cnt_inc = sat_inc(r_cnt);

  always_comb begin
    w_state_nx = r_state;
    w_col_nx   = r_col;
    w_row_nx   = r_row;
    w_dwell_nx = r_dwell;
    w_cnt_nx   = r_cnt;
    w_key_nx   = r_key;
    w_valid_nx = 1'b0;
    w_held_nx  = r_held;
    case (r_state)
      SCAN: begin
        if (r_dwell == DWELL_LAST) begin
          w_dwell_nx = '0;
          if (r_row_s != 4'hF) begin
            w_row_nx   = lowest_low(r_row_s);
            w_cnt_nx   = '0;
            w_state_nx = DEBOUNCE;
          end else begin
            w_col_nx = r_col + 2'd1;
          end
        end else begin
          w_dwell_nx = sat_inc(r_dwell);
        end
      end
      DEBOUNCE: begin
        if (w_row_low) begin
          w_cnt_nx = w_cnt_inc;
          if (w_cnt_inc >= DB_LAST) begin
            w_state_nx = HELD;
            w_cnt_nx   = '0;
            w_key_nx   = key_map(r_row, r_col);
            w_valid_nx = 1'b1;
            w_held_nx  = 1'b1;
          end
        end else begin
          // Bounce: abandon this column and keep scanning from the next one.
          w_state_nx = SCAN;
          w_col_nx   = r_col + 2'd1;
          w_dwell_nx = '0;
        end
      end
      HELD: begin
        if (!w_row_low) begin
          w_state_nx = RELEASE;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        if (w_row_low) begin
          w_state_nx = HELD;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = w_cnt_inc;
          if (w_cnt_inc >= DB_LAST) begin
            w_state_nx = SCAN;
            w_held_nx  = 1'b0;
            w_cnt_nx   = '0;
            w_col_nx   = r_col + 2'd1;
            w_dwell_nx = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_m <= 4'hF;
      r_row_s <= 4'hF;
      r_state <= SCAN;
      r_col   <= 2'd0;
      r_row   <= 2'd0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_key   <= 4'h0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_row_m <= row_n;
      r_row_s <= r_row_m;
      r_state <= w_state_nx;
      r_col   <= w_col_nx;
      r_row   <= w_row_nx;
      r_dwell <= w_dwell_nx;
      r_cnt   <= w_cnt_nx;
      r_key   <= w_key_nx;
      r_valid <= w_valid_nx;
      r_held  <= w_held_nx;
    end
  end

  assign col_n     = ~(4'b0001 << r_col);
  assign key       = r_key;
  assign key_valid = r_valid;
  assign key_held  = r_held;
endmodule
